// File: rtl/i2c_burst_reg_bridge.sv
// ---------------------------------------------------------------------------
// i2c_burst_reg_bridge
//
// Purpose: connects an I2C slave byte/strobe interface to a register file.
// A write frame carries a register pointer (ADDR_BYTES bytes, MSB first)
// followed by any number of little-endian registers of DATA_BYTES bytes
// each. A read frame streams little-endian registers starting at the
// retained pointer. Bursts are supported in both directions. A frame that
// ends in the middle of a register write raises frame_err_o.
//
// Optional feature macro: I2C_BRIDGE_AUTOINC_EN
//   defined   -> pointer advances by one after every committed write and
//                every completed register read
//   undefined -> pointer never advances (bursts hit the same register)
//
// Parameters:
//   ADDR_W      register pointer width, 8 or 16
//   DATA_BYTES  bytes per register, 1..4 (register width DW = 8*DATA_BYTES)
//
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   i2c_rx_data_i/wr_req_i received byte and its one-cycle strobe
//   rd_req_i               master consumed the current i2c_tx_data_o byte
//   i2c_tx_data_o          byte to transmit
//   addr_match_i/rw_bit_i  slave address matched, R/W bit (1 = read)
//   start_detected_i       START / repeated-START strobe
//   stop_detected_i        STOP strobe
//   addr_o                 register pointer
//   wr_en_o/wdata_o        one-cycle register write strobe and data
//   rd_en_o/rdata_i        one-cycle register read strobe; data next cycle
//   frame_err_o            one-cycle pulse: frame ended mid-register write
// ---------------------------------------------------------------------------
module i2c_burst_reg_bridge #(
  parameter int ADDR_W     = 8,
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [7:0]              i2c_rx_data_i,
  input  logic                    wr_req_i,
  input  logic                    rd_req_i,
  output logic [7:0]              i2c_tx_data_o,
  input  logic                    addr_match_i,
  input  logic                    rw_bit_i,
  input  logic                    start_detected_i,
  input  logic                    stop_detected_i,
  output logic [ADDR_W-1:0]       addr_o,
  output logic                    wr_en_o,
  output logic                    rd_en_o,
  output logic [8*DATA_BYTES-1:0] wdata_o,
  input  logic [8*DATA_BYTES-1:0] rdata_i,
  output logic                    frame_err_o
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int DW         = 8 * DATA_BYTES;
  localparam int CNT_MAX    = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW         = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] PTR_LAST  = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PTR     = 3'd1;
  localparam logic [2:0] S_WDATA   = 3'd2;
  localparam logic [2:0] S_WCOMMIT = 3'd3;
  localparam logic [2:0] S_RFETCH  = 3'd4;
  localparam logic [2:0] S_RLATCH  = 3'd5;
  localparam logic [2:0] S_RDATA   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rbuf_q, rbuf_d;
  logic [CW-1:0]     byte_cnt_q, byte_cnt_d;
  logic              frame_err_q, frame_err_d;

  logic [ADDR_W-1:0]     addr_adv;
  logic [DATA_BYTES-1:0] lane_sel;

  // One-hot byte-lane select from the counter. No lane is selected once the
  // counter reaches DATA_BYTES, which is what forces the tx byte to 0x00.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      assign lane_sel[gi] = (byte_cnt_q == CW'(gi));
    end
  endgenerate

`ifdef I2C_BRIDGE_AUTOINC_EN
  assign addr_adv = addr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
`else
  assign addr_adv = addr_q;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    byte_cnt_d  = byte_cnt_q;
    frame_err_d = 1'b0;

    // STOP/START outrank every other input; any strobe in the same cycle
    // is dropped. Pointer and read buffer are deliberately kept.
    if (stop_detected_i || start_detected_i) begin
      state_d     = S_IDLE;
      byte_cnt_d  = '0;
      frame_err_d = (state_q == S_WDATA) && (byte_cnt_q != '0);
    end else begin
      case (state_q)
        S_IDLE: begin
          byte_cnt_d = '0;
          if (addr_match_i) begin
            state_d = rw_bit_i ? S_RFETCH : S_PTR;
          end
        end
        S_PTR: begin
          if (wr_req_i) begin
            // Pointer bytes arrive MSB first: shift left, keep low ADDR_W bits
            addr_d = ADDR_W'({addr_q, i2c_rx_data_i});
            if (byte_cnt_q == PTR_LAST) begin
              byte_cnt_d = '0;
              state_d    = S_WDATA;
            end else begin
              byte_cnt_d = byte_cnt_q + CNT_ONE;
            end
          end
        end
        S_WDATA: begin
          if (wr_req_i) begin
            for (int k = 0; k < DATA_BYTES; k++) begin
              if (lane_sel[k]) begin
                wdata_d[8*k +: 8] = i2c_rx_data_i;
              end
            end
            byte_cnt_d = byte_cnt_q + CNT_ONE;
            if (byte_cnt_q == DATA_LAST) begin
              state_d = S_WCOMMIT;
            end
          end
        end
        S_WCOMMIT: begin
          addr_d     = addr_adv;
          byte_cnt_d = '0;
          state_d    = S_WDATA;
        end
        S_RFETCH: begin
          state_d = S_RLATCH;
        end
        S_RLATCH: begin
          rbuf_d     = rdata_i;
          byte_cnt_d = '0;
          state_d    = S_RDATA;
        end
        S_RDATA: begin
          if (rd_req_i) begin
            byte_cnt_d = byte_cnt_q + CNT_ONE;
            if (byte_cnt_q == DATA_LAST) begin
              addr_d  = addr_adv;
              state_d = S_RFETCH;
            end
          end
        end
        default: begin
          state_d    = S_IDLE;
          byte_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      byte_cnt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Little-endian transmit mux; 0x00 once the register is exhausted.
  always_comb begin
    i2c_tx_data_o = 8'h00;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (lane_sel[k]) begin
        i2c_tx_data_o = rbuf_q[8*k +: 8];
      end
    end
  end

  // Strobes decode straight from state so an asynchronous reset clears them
  // in the same cycle.
  assign wr_en_o     = (state_q == S_WCOMMIT);
  assign rd_en_o     = (state_q == S_RFETCH);
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign frame_err_o = frame_err_q;

endmodule
